add_rs: RTL and testbench

Reservation-station bank for the integer adder functional units in the Tomasulo core. It accepts issued ALU ops from the issue stage and snoops the CDB broadcast (Data_valid/Tag_out/Data_out) to capture pending operands. It dispatches operand-complete entries to the adder pipeline. Each entry owns a fixed producer tag and stays allocated until the CDB broadcasts that tag's result.

---
 rtl/tomasulo_pkg.sv | 30 +++
 rtl/add_rs_if.sv | 39 +++
 rtl/rs_entry.sv | 79 +++++++
 rtl/add_rs.sv | 88 ++++++++
 tb/tb_add_rs.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tomasulo_pkg.sv
// rtl/tomasulo_pkg.sv - shared widths, RS entry types and CDB tag match helper
package tomasulo_pkg;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [TAG_W-1:0] TAG_NONE = 4'd0;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2,
    EXEC  = 2'd3
  } rs_state_e;

  typedef struct packed {
    rs_state_e           state;
    logic [OP_W-1:0]     op;
    logic [DATA_W-1:0]   vj;
    logic [TAG_W-1:0]    qj;
    logic [DATA_W-1:0]   vk;
    logic [TAG_W-1:0]    qk;
  } rs_entry_t;

  // Tag 0 means "value present" and must never match a broadcast.
  function automatic logic tag_hit(input logic valid, input logic [TAG_W-1:0] q,
                                   input logic [TAG_W-1:0] cdb_tag);
    return valid && (q != TAG_NONE) && (q == cdb_tag);
  endfunction
endpackage

// File: rtl/add_rs_if.sv
// rtl/add_rs_if.sv - issue, CDB snoop and dispatch signal bundle for add_rs
interface add_rs_if #(
  parameter int NUM_ENTRIES = 3
);
  import tomasulo_pkg::*;

  logic                    issue_valid;
  logic [OP_W-1:0]         issue_op;
  logic [DATA_W-1:0]       issue_vj;
  logic [TAG_W-1:0]        issue_qj;
  logic [DATA_W-1:0]       issue_vk;
  logic [TAG_W-1:0]        issue_qk;
  logic                    issue_ready;
  logic [TAG_W-1:0]        issue_tag;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [TAG_W-1:0]        disp_tag;
  logic [OP_W-1:0]         disp_op;
  logic [DATA_W-1:0]       disp_a;
  logic [DATA_W-1:0]       disp_b;
  logic [NUM_ENTRIES-1:0]  entry_busy;

  modport master (
    output issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    output cdb_valid, cdb_tag, cdb_data, disp_ready,
    input  issue_ready, issue_tag, disp_valid, disp_tag, disp_op, disp_a, disp_b,
    input  entry_busy
  );

  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_qj, issue_vk, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data, disp_ready,
    output issue_ready, issue_tag, disp_valid, disp_tag, disp_op, disp_a, disp_b,
    output entry_busy
  );
endinterface

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - one reservation-station entry with issue bypass, CDB snoop and lifecycle
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter logic [TAG_W-1:0] MY_TAG = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_alloc,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_vj,
  input  logic [TAG_W-1:0]  i_qj,
  input  logic [DATA_W-1:0] i_vk,
  input  logic [TAG_W-1:0]  i_qk,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_data,
  input  logic              i_disp_grant,
  output rs_state_e         o_state,
  output logic [OP_W-1:0]   o_op,
  output logic [DATA_W-1:0] o_vj,
  output logic [DATA_W-1:0] o_vk
);
  rs_entry_t r_entry;
  rs_entry_t w_next;
  logic      w_byp_j;
  logic      w_byp_k;
  logic      w_hit_j;
  logic      w_hit_k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_entry <= '0;
    else       r_entry <= w_next;
  end

  always_comb begin
    w_next  = r_entry;
    w_byp_j = tag_hit(i_cdb_valid, i_qj, i_cdb_tag);
    w_byp_k = tag_hit(i_cdb_valid, i_qk, i_cdb_tag);
    w_hit_j = tag_hit(i_cdb_valid, r_entry.qj, i_cdb_tag);
    w_hit_k = tag_hit(i_cdb_valid, r_entry.qk, i_cdb_tag);
    case (r_entry.state)
      FREE: begin
        if (i_alloc) begin
          w_next.op    = i_op;
          w_next.vj    = w_byp_j ? i_cdb_data : i_vj;
          w_next.qj    = w_byp_j ? TAG_NONE : i_qj;
          w_next.vk    = w_byp_k ? i_cdb_data : i_vk;
          w_next.qk    = w_byp_k ? TAG_NONE : i_qk;
          w_next.state = (w_next.qj == TAG_NONE && w_next.qk == TAG_NONE) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (w_hit_j) begin
          w_next.vj = i_cdb_data;
          w_next.qj = TAG_NONE;
        end
        if (w_hit_k) begin
          w_next.vk = i_cdb_data;
          w_next.qk = TAG_NONE;
        end
        if (w_next.qj == TAG_NONE && w_next.qk == TAG_NONE) w_next.state = READY;
      end
      READY: begin
        if (i_disp_grant) w_next.state = EXEC;
      end
      EXEC: begin
        // Only our own result retires the entry; the slot is cleared for the next issue.
        if (i_cdb_valid && i_cdb_tag == MY_TAG) w_next = '0;
      end
      default: w_next = '0;
    endcase
  end

  assign o_state = r_entry.state;
  assign o_op    = r_entry.op;
  assign o_vj    = r_entry.vj;
  assign o_vk    = r_entry.vk;
endmodule

// File: rtl/add_rs.sv
// rtl/add_rs.sv - adder reservation-station bank: lowest-free allocation, lowest-ready dispatch
module add_rs
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int TAG_BASE    = 1
) (
  input logic   clk,
  input logic   reset,
  add_rs_if.slave rs
);
  rs_state_e              w_state [NUM_ENTRIES];
  logic [OP_W-1:0]        w_op    [NUM_ENTRIES];
  logic [DATA_W-1:0]      w_vj    [NUM_ENTRIES];
  logic [DATA_W-1:0]      w_vk    [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_alloc;
  logic [NUM_ENTRIES-1:0] w_grant;
  logic [NUM_ENTRIES-1:0] w_busy;
  logic                   w_any_free;
  logic [TAG_W-1:0]       w_free_tag;
  logic                   w_any_ready;
  logic [TAG_W-1:0]       w_disp_tag;
  logic [OP_W-1:0]        w_disp_op;
  logic [DATA_W-1:0]      w_disp_a;
  logic [DATA_W-1:0]      w_disp_b;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    rs_entry #(
      .MY_TAG(TAG_W'(TAG_BASE + g))
    ) u_entry (
      .clk          (clk),
      .reset        (reset),
      .i_alloc      (w_alloc[g]),
      .i_op         (rs.issue_op),
      .i_vj         (rs.issue_vj),
      .i_qj         (rs.issue_qj),
      .i_vk         (rs.issue_vk),
      .i_qk         (rs.issue_qk),
      .i_cdb_valid  (rs.cdb_valid),
      .i_cdb_tag    (rs.cdb_tag),
      .i_cdb_data   (rs.cdb_data),
      .i_disp_grant (w_grant[g]),
      .o_state      (w_state[g]),
      .o_op         (w_op[g]),
      .o_vj         (w_vj[g]),
      .o_vk         (w_vk[g])
    );
  end

  // Both encoders look only at registered entry state, so a slot freed this cycle is not reusable until next.
  always_comb begin
    w_any_free  = 1'b0;
    w_free_tag  = TAG_NONE;
    w_alloc     = '0;
    w_any_ready = 1'b0;
    w_grant     = '0;
    w_disp_tag  = TAG_NONE;
    w_disp_op   = '0;
    w_disp_a    = '0;
    w_disp_b    = '0;
    w_busy      = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_busy[i] = (w_state[i] != FREE);
      if (!w_any_free && w_state[i] == FREE) begin
        w_any_free = 1'b1;
        w_free_tag = TAG_W'(TAG_BASE + i);
        w_alloc[i] = rs.issue_valid;
      end
      if (!w_any_ready && w_state[i] == READY) begin
        w_any_ready = 1'b1;
        w_grant[i]  = rs.disp_ready;
        w_disp_tag  = TAG_W'(TAG_BASE + i);
        w_disp_op   = w_op[i];
        w_disp_a    = w_vj[i];
        w_disp_b    = w_vk[i];
      end
    end
  end

  assign rs.issue_ready = w_any_free;
  assign rs.issue_tag   = w_free_tag;
  assign rs.disp_valid  = w_any_ready;
  assign rs.disp_tag    = w_disp_tag;
  assign rs.disp_op     = w_disp_op;
  assign rs.disp_a      = w_disp_a;
  assign rs.disp_b      = w_disp_b;
  assign rs.entry_busy  = w_busy;
endmodule

// File: tb/tb_add_rs.sv
// tb/tb_add_rs.sv - directed and randomized checks of add_rs against a slot-list reference model
module tb_add_rs;
  localparam int N  = 3;
  localparam int TB = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  add_rs_if #(.NUM_ENTRIES(N)) rs_if ();

  add_rs #(.NUM_ENTRIES(N), .TAG_BASE(TB)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a slot is held from issue until its tag comes back after dispatch.
  bit          m_held [N];
  bit          m_sent [N];
  logic [3:0]  m_op   [N];
  logic [31:0] m_a    [N];
  logic [31:0] m_b    [N];
  logic [3:0]  m_qa   [N];
  logic [3:0]  m_qb   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int i);
    return m_held[i] && !m_sent[i] && m_qa[i] == 0 && m_qb[i] == 0;
  endfunction

  function automatic int m_first_free();
    for (int i = 0; i < N; i++) if (!m_held[i]) return i;
    return -1;
  endfunction

  function automatic int m_first_ready();
    for (int i = 0; i < N; i++) if (m_ready(i)) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_held[i] = 0; m_sent[i] = 0; m_op[i] = 0;
      m_a[i] = 0; m_b[i] = 0; m_qa[i] = 0; m_qb[i] = 0;
    end
  endtask

  task automatic check_model();
    int f;
    int r;
    logic [N-1:0] busy;
    f = m_first_free();
    r = m_first_ready();
    for (int i = 0; i < N; i++) busy[i] = m_held[i];
    chk("issue_ready", 32'(rs_if.issue_ready), 32'(f >= 0));
    if (f >= 0) chk("issue_tag", 32'(rs_if.issue_tag), 32'(TB + f));
    chk("disp_valid", 32'(rs_if.disp_valid), 32'(r >= 0));
    if (r >= 0) begin
      chk("disp_tag", 32'(rs_if.disp_tag), 32'(TB + r));
      chk("disp_op", 32'(rs_if.disp_op), 32'(m_op[r]));
      chk("disp_a", rs_if.disp_a, m_a[r]);
      chk("disp_b", rs_if.disp_b, m_b[r]);
    end
    chk("entry_busy", 32'(rs_if.entry_busy), 32'(busy));
  endtask

  task automatic model_next();
    int f;
    int r;
    bit hit;
    f = m_first_free();
    r = m_first_ready();
    for (int i = 0; i < N; i++) begin
      hit = rs_if.cdb_valid && rs_if.cdb_tag == 4'(TB + i);
      if (m_held[i] && m_sent[i] && hit) begin
        m_held[i] = 0; m_sent[i] = 0;
      end else if (m_held[i] && !m_sent[i]) begin
        if (i == r && rs_if.disp_ready) m_sent[i] = 1;
        if (rs_if.cdb_valid && m_qa[i] != 0 && m_qa[i] == rs_if.cdb_tag) begin
          m_a[i] = rs_if.cdb_data; m_qa[i] = 0;
        end
        if (rs_if.cdb_valid && m_qb[i] != 0 && m_qb[i] == rs_if.cdb_tag) begin
          m_b[i] = rs_if.cdb_data; m_qb[i] = 0;
        end
      end else if (!m_held[i] && i == f && rs_if.issue_valid) begin
        m_held[i] = 1;
        m_op[i]   = rs_if.issue_op;
        m_a[i]    = rs_if.issue_vj;
        m_qa[i]   = rs_if.issue_qj;
        m_b[i]    = rs_if.issue_vk;
        m_qb[i]   = rs_if.issue_qk;
        if (rs_if.cdb_valid && m_qa[i] != 0 && m_qa[i] == rs_if.cdb_tag) begin
          m_a[i] = rs_if.cdb_data; m_qa[i] = 0;
        end
        if (rs_if.cdb_valid && m_qb[i] != 0 && m_qb[i] == rs_if.cdb_tag) begin
          m_b[i] = rs_if.cdb_data; m_qb[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    check_model();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_if.issue_valid = 0; rs_if.issue_op = 0;
    rs_if.issue_vj = 0; rs_if.issue_qj = 0; rs_if.issue_vk = 0; rs_if.issue_qk = 0;
    rs_if.cdb_valid = 0; rs_if.cdb_tag = 0; rs_if.cdb_data = 0;
    rs_if.disp_ready = 0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk);
    rs_if.issue_valid = 1; rs_if.issue_op = op;
    rs_if.issue_vj = vj; rs_if.issue_qj = qj; rs_if.issue_vk = vk; rs_if.issue_qk = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    rs_if.cdb_valid = 1; rs_if.cdb_tag = tag; rs_if.cdb_data = data;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #1;
    m_clear();
    chk("rst_busy", 32'(rs_if.entry_busy), 32'(0));
    chk("rst_disp_valid", 32'(rs_if.disp_valid), 32'(0));
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    idle();
    m_clear();
    @(posedge clk);
    #1;
    chk("reset_issue_ready", 32'(rs_if.issue_ready), 32'(1));
    chk("reset_issue_tag", 32'(rs_if.issue_tag), 32'(TB));
    chk("reset_disp_valid", 32'(rs_if.disp_valid), 32'(0));
    chk("reset_disp_tag", 32'(rs_if.disp_tag), 32'(0));
    chk("reset_disp_a", rs_if.disp_a, 32'(0));
    chk("reset_disp_b", rs_if.disp_b, 32'(0));
    chk("reset_busy", 32'(rs_if.entry_busy), 32'(0));
    reset = 0;

    // Plain issue with both operands present.
    issue(4'd0, 32'd5, 4'd0, 32'd7, 4'd0);
    chk("t1_issue_tag", 32'(rs_if.issue_tag), 32'(1));
    step(); idle();
    chk("t1_disp_valid", 32'(rs_if.disp_valid), 32'(1));
    chk("t1_disp_tag", 32'(rs_if.disp_tag), 32'(1));
    chk("t1_disp_a", rs_if.disp_a, 32'd5);
    chk("t1_disp_b", rs_if.disp_b, 32'd7);

    // Operand captured by snoop two cycles after issue.
    do_reset();
    issue(4'd3, 32'h99, 4'd4, 32'd3, 4'd0);
    step(); idle();
    step();
    cdb(4'd4, 32'h1234);
    chk("t2_wait", 32'(rs_if.disp_valid), 32'(0));
    step(); idle();
    chk("t2_disp_valid", 32'(rs_if.disp_valid), 32'(1));
    chk("t2_disp_a", rs_if.disp_a, 32'h1234);
    chk("t2_disp_b", rs_if.disp_b, 32'd3);

    // Issue-cycle bypass.
    do_reset();
    issue(4'd1, 32'h55, 4'd4, 32'd9, 4'd0);
    cdb(4'd4, 32'hAA);
    step(); idle();
    chk("t3_disp_valid", 32'(rs_if.disp_valid), 32'(1));
    chk("t3_disp_a", rs_if.disp_a, 32'hAA);

    // Full bank, ignored issue, free one slot.
    do_reset();
    issue(4'd2, 32'd1, 4'd9, 32'd2, 4'd0); step();
    issue(4'd4, 32'd3, 4'd0, 32'd4, 4'd0); step();
    issue(4'd6, 32'd5, 4'd9, 32'd6, 4'd0); step();
    chk("t4_full_ready", 32'(rs_if.issue_ready), 32'(0));
    chk("t4_full_busy", 32'(rs_if.entry_busy), 32'(3'b111));
    issue(4'd7, 32'd8, 4'd0, 32'd8, 4'd0); step(); idle();
    chk("t4_ignored_busy", 32'(rs_if.entry_busy), 32'(3'b111));
    chk("t4_disp_tag", 32'(rs_if.disp_tag), 32'(2));
    rs_if.disp_ready = 1; step(); idle();
    chk("t4_exec_no_offer", 32'(rs_if.disp_valid), 32'(0));
    cdb(4'd2, 32'hDEAD);
    chk("t4_no_same_cycle", 32'(rs_if.issue_ready), 32'(0));
    step(); idle();
    chk("t4_freed_ready", 32'(rs_if.issue_ready), 32'(1));
    chk("t4_freed_tag", 32'(rs_if.issue_tag), 32'(2));

    // Held offer under backpressure; own-tag broadcast outside EXEC is ignored.
    do_reset();
    issue(4'd1, 32'd10, 4'd0, 32'd11, 4'd0); step();
    issue(4'd2, 32'd20, 4'd0, 32'd21, 4'd0); step(); idle();
    for (int c = 0; c < 3; c++) begin
      if (c == 1) cdb(4'd1, 32'hBAD);
      step(); idle();
      chk("t5_hold_tag", 32'(rs_if.disp_tag), 32'(1));
    end
    rs_if.disp_ready = 1; step(); idle();
    chk("t5_next_tag", 32'(rs_if.disp_tag), 32'(2));
    chk("t5_next_a", rs_if.disp_a, 32'd20);
    rs_if.disp_ready = 1; step(); idle();
    chk("t6_both_exec", 32'(rs_if.entry_busy), 32'(3'b011));

    // Reset with two entries in EXEC, then a stale broadcast.
    do_reset();
    cdb(4'd1, 32'h1);
    step(); idle();
    chk("t6_stale_busy", 32'(rs_if.entry_busy), 32'(0));
    chk("t6_stale_tag", 32'(rs_if.issue_tag), 32'(1));

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] qsel [6];
      qsel[0] = 0; qsel[1] = 0; qsel[2] = 1; qsel[3] = 2; qsel[4] = 3; qsel[5] = 5;
      idle();
      if ($urandom_range(0, 99) < 50)
        issue(4'($urandom), $urandom, qsel[$urandom_range(0, 5)], $urandom, qsel[$urandom_range(0, 5)]);
      if ($urandom_range(0, 99) < 45) cdb(4'($urandom_range(0, 5)), $urandom);
      rs_if.disp_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    idle();
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
